// File: rtl/iob_cache_mem_arbiter.sv
// Round-robin arbiter sharing one native memory port between two requesters,
// with a watchdog that aborts transactions memory never acknowledges.
module iob_cache_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                r0_valid,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [DATA_W-1:0]   r0_wdata,
  input  logic [DATA_W/8-1:0] r0_wstrb,
  output logic [DATA_W-1:0]   r0_rdata,
  output logic                r0_ready,
  input  logic                r1_valid,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [DATA_W-1:0]   r1_wdata,
  input  logic [DATA_W/8-1:0] r1_wstrb,
  output logic [DATA_W-1:0]   r1_rdata,
  output logic                r1_ready,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, TOUT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             terr_q, terr_d;
  logic             gidx;

  assign gidx        = grant_q[1];
  assign grant       = grant_q;
  assign timeout_err = terr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          state_d = BUSY;
          cnt_d   = '0;
          // On a tie the requester not served last wins.
          if (r0_valid && r1_valid) grant_d = last_q ? 2'b01 : 2'b10;
          else                      grant_d = r1_valid ? 2'b10 : 2'b01;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d = IDLE;
          last_d  = gidx;
          grant_d = 2'b00;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) state_d = TOUT;
        end
      end
      TOUT: begin
        state_d = IDLE;
        last_d  = gidx;
        grant_d = 2'b00;
        cnt_d   = '0;
        terr_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = gidx ? r1_addr  : r0_addr;
    mem_wdata = gidx ? r1_wdata : r0_wdata;
    mem_wstrb = gidx ? r1_wstrb : r0_wstrb;
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    r0_rdata  = mem_rdata;
    r1_rdata  = mem_rdata;
    case (state_q)
      BUSY: begin
        mem_valid = 1'b1;
        r0_ready  = grant_q[0] & mem_ready;
        r1_ready  = grant_q[1] & mem_ready;
      end
      // Aborted transaction completes with zero data to the stalled requester.
      TOUT: begin
        r0_ready = grant_q[0];
        r1_ready = grant_q[1];
        if (grant_q[0]) r0_rdata = '0;
        if (grant_q[1]) r1_rdata = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_iob_cache_mem_arbiter.sv
// Bench for iob_cache_mem_arbiter: directed scenarios plus randomized traffic
// checked against a reference memory and round-robin arbitration rules.
module tb_iob_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_valid, r1_valid, r0_ready, r1_ready;
  logic [AW-1:0] r0_addr, r1_addr, mem_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, mem_wdata, mem_rdata;
  logic [SW-1:0] r0_wstrb, r1_wstrb, mem_wstrb;
  logic          mem_valid, mem_ready;
  logic [1:0]    grant;
  logic          timeout_err;

  int n_cmp = 0;
  int n_fail = 0;

  logic [DW-1:0] mem_arr [16];
  logic [DW-1:0] ref_mem [16];
  int mem_lat;
  int mem_wait;
  bit rand_lat;

  always #5 clk = ~clk;

  iob_cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_wstrb(r0_wstrb),
    .r0_rdata(r0_rdata), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_wstrb(r1_wstrb),
    .r1_rdata(r1_rdata), .r1_ready(r1_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [SW-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [1:0] onehot(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  // Memory model: answers after mem_lat stalled cycles; mem_lat < 0 never answers.
  task automatic mem_drive();
    if (!mem_valid) begin
      mem_wait  = 0;
      mem_ready = 1'b0;
      mem_rdata = $urandom | 32'h1;
      if (rand_lat) mem_lat = $urandom_range(0, 2);
    end else if (mem_lat >= 0 && mem_wait == mem_lat) begin
      mem_ready = 1'b1;
      mem_rdata = mem_arr[mem_addr[3:0]];
      if (mem_wstrb != '0) mem_arr[mem_addr[3:0]] = merge(mem_arr[mem_addr[3:0]], mem_wdata, mem_wstrb);
      mem_wait = 0;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom | 32'h1;
      mem_wait++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    mem_drive();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    r0_valid = 1'b1;
    tick(); tick();
    n_cmp++; if ({mem_valid, r0_ready, r1_ready} !== 3'b000) begin n_fail++;
      $display("FAIL reset_outputs: got %b want 000", {mem_valid, r0_ready, r1_ready}); end
    n_cmp++; if (grant !== 2'b00) begin n_fail++;
      $display("FAIL reset_grant: got %b want 00", grant); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++;
      $display("FAIL reset_terr: got %b want 0", timeout_err); end
    r0_valid = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    mem_lat = 1;
    mem_arr[4] = 32'hDEADBEEF;
    r0_valid = 1'b1; r0_addr = 32'h1234; r0_wstrb = '0; r0_wdata = $urandom;
    tick();
    n_cmp++; if ({mem_valid, grant} !== 3'b101) begin n_fail++;
      $display("FAIL rd_cycle1: got %b want 101", {mem_valid, grant}); end
    n_cmp++; if (mem_addr !== 32'h1234 || r0_ready !== 1'b0) begin n_fail++;
      $display("FAIL rd_addr: got %h/%b want 00001234/0", mem_addr, r0_ready); end
    tick();
    n_cmp++; if ({r1_ready, r0_ready} !== 2'b01) begin n_fail++;
      $display("FAIL rd_ready: got %b want 01", {r1_ready, r0_ready}); end
    n_cmp++; if (r0_rdata !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL rd_data: got %h want deadbeef", r0_rdata); end
    r0_valid = 1'b0;
    tick();
    n_cmp++; if ({mem_valid, grant, r0_ready} !== 4'b0000) begin n_fail++;
      $display("FAIL rd_idle: got %b want 0000", {mem_valid, grant, r0_ready}); end
  endtask

  task automatic test_write_read_r1();
    mem_lat = 1;
    r1_valid = 1'b1; r1_addr = 32'h0579; r1_wdata = 32'hCAFEEFAC; r1_wstrb = 4'hF;
    tick();
    n_cmp++; if (grant !== 2'b10 || mem_wstrb !== 4'hF) begin n_fail++;
      $display("FAIL wr_grant_strb: got %b/%h want 10/f", grant, mem_wstrb); end
    n_cmp++; if (mem_addr !== 32'h0579 || mem_wdata !== 32'hCAFEEFAC) begin n_fail++;
      $display("FAIL wr_fwd: got %h/%h want 00000579/cafeefac", mem_addr, mem_wdata); end
    tick();
    n_cmp++; if ({r1_ready, r0_ready} !== 2'b10) begin n_fail++;
      $display("FAIL wr_ready: got %b want 10", {r1_ready, r0_ready}); end
    r1_valid = 1'b0;
    tick();
    r1_valid = 1'b1; r1_wstrb = '0; r1_wdata = $urandom;
    tick();
    n_cmp++; if (mem_wstrb !== 4'h0) begin n_fail++;
      $display("FAIL rb_strb: got %h want 0", mem_wstrb); end
    tick();
    n_cmp++; if ({r1_ready, r0_ready} !== 2'b10 || r1_rdata !== 32'hCAFEEFAC) begin n_fail++;
      $display("FAIL rb_data: got %b/%h want 10/cafeefac", {r1_ready, r0_ready}, r1_rdata); end
    r1_valid = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    reset = 1'b0; tick(); reset = 1'b1;
    mem_lat = 1;
    r0_addr = 32'h10; r0_wstrb = '0; r1_addr = 32'h20; r1_wstrb = '0;
    r0_valid = 1'b1; r1_valid = 1'b1;
    exp = 2'b01;
    for (int t = 0; t < 8; t++) begin
      tick();
      n_cmp++; if ({mem_valid, grant} !== {1'b1, exp}) begin n_fail++;
        $display("FAIL cont_grant[%0d]: got %b want %b", t, {mem_valid, grant}, {1'b1, exp}); end
      tick();
      n_cmp++; if ({r1_ready, r0_ready} !== exp) begin n_fail++;
        $display("FAIL cont_ready[%0d]: got %b want %b", t, {r1_ready, r0_ready}, exp); end
      if (t == 7) begin r0_valid = 1'b0; r1_valid = 1'b0; end
      tick();
      n_cmp++; if ({mem_valid, grant} !== 3'b000) begin n_fail++;
        $display("FAIL cont_gap[%0d]: got %b want 000", t, {mem_valid, grant}); end
      exp = {exp[0], exp[1]};
    end
  endtask

  task automatic test_timeout();
    mem_lat = -1;
    r0_valid = 1'b1; r0_addr = 32'h40; r0_wstrb = '0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      n_cmp++; if ({mem_valid, r0_ready} !== 2'b10) begin n_fail++;
        $display("FAIL tout_busy[%0d]: got %b want 10", k, {mem_valid, r0_ready}); end
    end
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++;
      $display("FAIL tout_early: got %b want 0", timeout_err); end
    tick();
    n_cmp++; if ({mem_valid, r1_ready, r0_ready} !== 3'b001) begin n_fail++;
      $display("FAIL tout_ready: got %b want 001", {mem_valid, r1_ready, r0_ready}); end
    n_cmp++; if (r0_rdata !== 32'h0) begin n_fail++;
      $display("FAIL tout_rdata: got %h want 0", r0_rdata); end
    r0_valid = 1'b0;
    tick();
    n_cmp++; if ({timeout_err, grant} !== 3'b100) begin n_fail++;
      $display("FAIL tout_flag: got %b want 100", {timeout_err, grant}); end
    tick(); tick();
    n_cmp++; if (timeout_err !== 1'b1) begin n_fail++;
      $display("FAIL tout_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_race();
    reset = 1'b0; tick(); reset = 1'b1;
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++;
      $display("FAIL race_clear: got %b want 0", timeout_err); end
    mem_lat = 3;
    mem_arr[5] = 32'h5A5AA5A5;
    r0_valid = 1'b1; r0_addr = 32'h5; r0_wstrb = '0;
    for (int k = 1; k < TO; k++) begin
      tick();
      n_cmp++; if ({mem_valid, r0_ready} !== 2'b10) begin n_fail++;
        $display("FAIL race_wait[%0d]: got %b want 10", k, {mem_valid, r0_ready}); end
    end
    tick();
    n_cmp++; if (r0_ready !== 1'b1 || r0_rdata !== 32'h5A5AA5A5) begin n_fail++;
      $display("FAIL race_done: got %b/%h want 1/5a5aa5a5", r0_ready, r0_rdata); end
    r0_valid = 1'b0;
    tick();
    n_cmp++; if ({mem_valid, r0_ready, r1_ready, grant} !== 5'b00000) begin n_fail++;
      $display("FAIL race_idle: got %b want 00000", {mem_valid, r0_ready, r1_ready, grant}); end
    tick();
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++;
      $display("FAIL race_terr: got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid();
    mem_lat = -1;
    r1_valid = 1'b1; r1_addr = 32'h77; r1_wstrb = '0;
    tick();
    n_cmp++; if ({mem_valid, grant} !== 3'b110) begin n_fail++;
      $display("FAIL rmid_busy: got %b want 110", {mem_valid, grant}); end
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if ({mem_valid, grant, r1_ready, timeout_err} !== 5'b00000) begin n_fail++;
      $display("FAIL rmid_abort: got %b want 00000", {mem_valid, grant, r1_ready, timeout_err}); end
    reset = 1'b1; r1_valid = 1'b0;
    tick();
    mem_lat = 1;
    r0_valid = 1'b1; r0_addr = 32'h3; r0_wstrb = '0; r1_valid = 1'b1;
    tick();
    n_cmp++; if (grant !== 2'b01) begin n_fail++;
      $display("FAIL rmid_tiewin: got %b want 01", grant); end
    tick();
    n_cmp++; if ({r1_ready, r0_ready} !== 2'b01) begin n_fail++;
      $display("FAIL rmid_ready: got %b want 01", {r1_ready, r0_ready}); end
    r0_valid = 1'b0; r1_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit pend[2];
    bit just[2];
    logic [AW-1:0] q_addr[2];
    logic [DW-1:0] q_wdata[2];
    logic [SW-1:0] q_wstrb[2];
    logic [1:0] presented, prev_presented, rdy;
    logic [DW-1:0] rd;
    bit prev_mv, prev_idle;
    int served, last_served, exp_w, n_done;
    reset = 1'b0; tick(); reset = 1'b1;
    for (int i = 0; i < 16; i++) begin mem_arr[i] = $urandom; ref_mem[i] = mem_arr[i]; end
    rand_lat = 1'b1;
    for (int i = 0; i < 2; i++) begin pend[i] = 0; q_addr[i] = '0; q_wdata[i] = '0; q_wstrb[i] = '0; end
    prev_presented = 2'b00; prev_mv = 0; prev_idle = 1; served = -1; last_served = 1; n_done = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      tick();
      rdy = {r1_ready, r0_ready};
      if (prev_idle && prev_presented != 2'b00) begin
        n_cmp++; if (mem_valid !== 1'b1) begin n_fail++;
          $display("FAIL rnd_latency[%0d]: got %b want 1", cyc, mem_valid); end
      end
      if (mem_valid && !prev_mv && prev_presented != 2'b00) begin
        exp_w = (prev_presented == 2'b11) ? 1 - last_served : (prev_presented[1] ? 1 : 0);
        n_cmp++; if (grant !== onehot(exp_w)) begin n_fail++;
          $display("FAIL rnd_grant[%0d]: got %b want %b", cyc, grant, onehot(exp_w)); end
        n_cmp++; if ({mem_addr, mem_wdata, mem_wstrb} !== {q_addr[exp_w], q_wdata[exp_w], q_wstrb[exp_w]}) begin
          n_fail++;
          $display("FAIL rnd_fwd[%0d]: got %h/%h/%h want %h/%h/%h", cyc, mem_addr, mem_wdata, mem_wstrb,
                   q_addr[exp_w], q_wdata[exp_w], q_wstrb[exp_w]); end
        served = exp_w;
      end
      just[0] = 0; just[1] = 0;
      if (rdy != 2'b00) begin
        n_cmp++;
        if (served < 0 || rdy !== onehot(served)) begin n_fail++;
          $display("FAIL rnd_ready[%0d]: got %b want %0d-served", cyc, rdy, served);
        end else begin
          if (q_wstrb[served] == '0) begin
            rd = (served == 1) ? r1_rdata : r0_rdata;
            n_cmp++; if (rd !== ref_mem[q_addr[served][3:0]]) begin n_fail++;
              $display("FAIL rnd_rdata[%0d]: got %h want %h", cyc, rd, ref_mem[q_addr[served][3:0]]); end
          end else begin
            ref_mem[q_addr[served][3:0]] = merge(ref_mem[q_addr[served][3:0]], q_wdata[served], q_wstrb[served]);
          end
          pend[served] = 0; just[served] = 1; last_served = served; n_done++;
        end
        served = -1;
      end
      prev_mv = mem_valid;
      prev_idle = !mem_valid && grant == 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && !just[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          q_addr[i] = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 7));
          q_wdata[i] = $urandom;
          q_wstrb[i] = ($urandom_range(0, 1) == 1) ? SW'($urandom_range(1, 15)) : '0;
        end
      end
      r0_valid = pend[0]; r0_addr = q_addr[0]; r0_wdata = q_wdata[0]; r0_wstrb = q_wstrb[0];
      r1_valid = pend[1]; r1_addr = q_addr[1]; r1_wdata = q_wdata[1]; r1_wstrb = q_wstrb[1];
      presented = {pend[1], pend[0]};
      prev_presented = presented;
    end
    n_cmp++; if (n_done < 50) begin n_fail++;
      $display("FAIL rnd_progress: got %0d want >=50", n_done); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_fail++;
      $display("FAIL rnd_terr: got %b want 0", timeout_err); end
    r0_valid = 1'b0; r1_valid = 1'b0; rand_lat = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  initial begin
    reset = 1'b0;
    r0_valid = 1'b0; r0_addr = '0; r0_wdata = '0; r0_wstrb = '0;
    r1_valid = 1'b0; r1_addr = '0; r1_wdata = '0; r1_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    mem_lat = 1; mem_wait = 0; rand_lat = 1'b0;
    for (int i = 0; i < 16; i++) begin mem_arr[i] = '0; ref_mem[i] = '0; end
    test_reset();
    test_single_read();
    test_write_read_r1();
    test_contention();
    test_timeout();
    test_race();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_cache_mem_arbiter.md
Name: iob_cache_mem_arbiter

Overview:
- Two-requester round-robin arbiter sharing one native memory port (valid/ready, addr, wdata, wstrb, rdata), e.g. the instruction and data caches in front of a single iob_sp_ram-style back-end.
- Latches a grant, forwards the granted requester's transaction to memory and routes ready/rdata back.
- A watchdog aborts transactions that memory never acknowledges.

Parameters:
- ADDR_W, 32, address width of requester and memory ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- TIMEOUT, 255, maximum BUSY cycles without mem_ready before abort; 0 disables the watchdog. Counter width is $clog2(TIMEOUT+1), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low: reset==0 at a clk edge resets the block.
- r0_valid  in  1  requester 0 request; held until r0_ready.
- r0_addr  in  ADDR_W  requester 0 address.
- r0_wdata  in  DATA_W  requester 0 write data.
- r0_wstrb  in  DATA_W/8  requester 0 byte strobes; 0 means read.
- r0_rdata  out  DATA_W  requester 0 read data.
- r0_ready  out  1  requester 0 completion pulse.
- r1_valid, r1_addr, r1_wdata, r1_wstrb, r1_rdata, r1_ready: same as r0_*, for requester 1.
- mem_valid  out  1  memory request.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  DATA_W/8  memory strobes.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completion pulse.
- grant  out  2  one-hot current grant, 00 when idle.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset state: IDLE, grant=00, last=1 (requester 0 wins the first tie), cnt=0, timeout_err=0.
- Outputs while in reset/IDLE: mem_valid=0, r0_ready=r1_ready=0.
- States: IDLE, BUSY, TOUT.
- IDLE arbitration:
  - If any rX_valid=1, register grant and go to BUSY.
  - Only one valid: grant it.
  - Both valid: grant the requester whose index differs from last.
  - No valid: stay in IDLE.
- BUSY datapath:
  - mem_valid=1.
  - mem_addr/mem_wdata/mem_wstrb = granted requester's inputs, muxed combinationally from grant.
  - Granted rX_ready = mem_ready, combinational. The other ready = 0.
- rdata: r0_rdata and r1_rdata both equal mem_rdata, except in TOUT.
- BUSY with mem_ready=1:
  - Next state IDLE, last <= granted index, grant <= 00, cnt <= 0.
  - mem_valid drops for at least one cycle between transactions.
- BUSY with mem_ready=0:
  - cnt increments.
  - If TOUT enabled (TIMEOUT!=0) and cnt==TIMEOUT-1 at the edge, next state is TOUT.
- TOUT (one cycle):
  - mem_valid=0.
  - Granted rX_ready=1 and its rX_rdata=0.
  - timeout_err <= 1, sticky until reset.
  - Then behaves as completion: last updated, grant 00, IDLE.
- Simultaneous mem_ready and timeout threshold: normal completion wins, no error.
- Latency: valid sampled in IDLE at cycle 0 → mem_valid at cycle 1 → requester ready in the same cycle mem_ready arrives. With a 1-cycle memory (mem_ready <= mem_valid), ready is at cycle 2.
- Back-to-back: after ready at cycle n, a request still asserted at cycle n+1 is re-arbitrated in IDLE, giving mem_valid at n+2.
- Requester must drop valid the cycle after ready, otherwise it is treated as a new request.
- Requester drops valid while BUSY: protocol violation. The transaction still runs to completion and ready still pulses.
- mem_ready while IDLE or TOUT: ignored.
- Reset asserted mid-transaction: abort. State IDLE, mem_valid=0 from the next cycle, no ready pulse generated.

Test Plan:
- Single read: r0_valid, r0_addr=0x1234, wstrb=0, 1-cycle memory model holding 0xDEADBEEF → mem_valid at cycle 1, r0_ready and r0_rdata=0xDEADBEEF at cycle 2, grant=01 then 00.
- Write then read-back via r1: r1 writes 0xCAFEEFAC, wstrb=0xF to 0x0579, then reads it → mem_wstrb=0xF on the write, read returns 0xCAFEEFAC, r0_ready stays 0.
- Contention fairness: r0 and r1 both valid continuously, 4 transactions each with immediate re-request → grant order 01,10,01,10..., one IDLE cycle between each, no starvation.
- Timeout: TIMEOUT=4, memory never answers, r0 reads → mem_valid high 4 cycles then low, r0_ready=1 with r0_rdata=0 in TOUT, timeout_err=1 and stays set.
- Race at threshold: TIMEOUT=4, mem_ready arrives in the 4th BUSY cycle → normal completion, r0_rdata=mem_rdata, timeout_err stays 0.
- Reset mid-BUSY: reset=0 during r1 transaction → next cycle mem_valid=0, grant=00, no r1_ready, timeout_err=0. After release, r0 tie-win is restored.
